// File: rtl/display_scan_scheduler_pkg.sv
// Purpose: shared state encodings and default parameters for the display scan scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: scan_state_t (S_IDLE/S_BLANK/S_SHOW), default parameter constants and the
//   max_int helper used to size the tick counter.
package display_scan_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } scan_state_t;

  localparam int DEF_NUM_DIGITS  = 4;
  localparam int DEF_SHOW_TICKS  = 4;
  localparam int DEF_BLANK_TICKS = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Purpose: two-flop synchronizer plus rising-edge detect; reusable for push-buttons.
// Latency: rise_pulse is high for one clock, 3 clocks after d rises.
// Backpressure: none; every qualifying rise produces exactly one pulse.
// Ports: clock (system clock), reset (async, active-high), d (asynchronous level),
//   rise_pulse (one-cycle registered pulse).
module sync_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic rise_pulse
);

  logic meta;
  logic sync;
  logic sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta       <= 1'b0;
      sync       <= 1'b0;
      sync_q     <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      meta       <= d;
      sync       <= meta;
      sync_q     <= sync;
      // Registered so the pulse is glitch-free and a full cycle wide.
      rise_pulse <= sync & ~sync_q;
    end
  end

endmodule

// File: rtl/display_scan_scheduler.sv
// Purpose: time-multiplexes a shared seven-segment cathode bus over NUM_DIGITS anodes.
// Latency: outputs registered; they change on the edge that changes the state.
// Backpressure: none; scan ticks are consumed as they arrive.
// Ports: clock, reset (async, active-high), div_clock (divided clock, sampled as data),
//   enable, digit_mask (digit i scanned when bit i = 1), anode (active-low, at most one 0),
//   digit_sel (cathode mux select), blank (all anodes off), frame_done (pulse on wrap).
module display_scan_scheduler
  import display_scan_scheduler_pkg::*;
#(
  parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
  parameter int SHOW_TICKS  = DEF_SHOW_TICKS,
  parameter int BLANK_TICKS = DEF_BLANK_TICKS,
  localparam int SEL_W      = $clog2(NUM_DIGITS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  div_clock,
  input  logic                  enable,
  input  logic [NUM_DIGITS-1:0] digit_mask,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [SEL_W-1:0]      digit_sel,
  output logic                  blank,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(max_int(SHOW_TICKS, BLANK_TICKS) + 1);

  scan_state_t             state, state_nx;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic [NUM_DIGITS-1:0]   anode_nx;
  logic [SEL_W-1:0]        sel_nx;
  logic                    blank_nx;
  logic                    fd_nx;
  logic                    tick;
  logic [SEL_W-1:0]        first_idx;
  logic [SEL_W-1:0]        next_idx;

  sync_edge_detect u_tick (
    .clock      (clock),
    .reset      (reset),
    .d          (div_clock),
    .rise_pulse (tick)
  );

  function automatic logic [NUM_DIGITS-1:0] lit_anode(input logic [SEL_W-1:0] sel);
    logic [NUM_DIGITS-1:0] a;
    a      = '1;
    a[sel] = 1'b0;
    return a;
  endfunction

  // Lowest set mask bit: scan downwards so the lowest index is written last.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (digit_mask[i]) first_idx = SEL_W'(i);
    end
  end

  // Next set bit above digit_sel with circular wrap. Offsets run from NUM_DIGITS down
  // to 1 so the nearest one wins; offset NUM_DIGITS lets a lone digit re-select itself.
  always_comb begin
    int idx;
    next_idx = digit_sel;
    for (int off = NUM_DIGITS; off >= 1; off--) begin
      idx = (int'(digit_sel) + off) % NUM_DIGITS;
      if (digit_mask[idx]) next_idx = SEL_W'(idx);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      anode      <= '1;
      digit_sel  <= '0;
      blank      <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      anode      <= anode_nx;
      digit_sel  <= sel_nx;
      blank      <= blank_nx;
      frame_done <= fd_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sel_nx   = digit_sel;
    anode_nx = anode;
    blank_nx = blank;
    fd_nx    = 1'b0;

    // enable has priority over any tick arriving in the same cycle.
    if (!enable) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      anode_nx = '1;
      blank_nx = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (|digit_mask) begin
            sel_nx = first_idx;
            cnt_nx = '0;
            if (BLANK_TICKS == 0) begin
              state_nx = S_SHOW;
              anode_nx = lit_anode(first_idx);
              blank_nx = 1'b0;
            end else begin
              state_nx = S_BLANK;
              anode_nx = '1;
              blank_nx = 1'b1;
            end
          end
        end

        S_BLANK: begin
          if (tick) begin
            if (cnt == CNT_W'(BLANK_TICKS - 1)) begin
              state_nx = S_SHOW;
              cnt_nx   = '0;
              anode_nx = lit_anode(digit_sel);
              blank_nx = 1'b0;
            end else begin
              cnt_nx = cnt + CNT_W'(1);
            end
          end
        end

        S_SHOW: begin
          if (tick) begin
            if (cnt == CNT_W'(SHOW_TICKS - 1)) begin
              cnt_nx = '0;
              if (!(|digit_mask)) begin
                state_nx = S_IDLE;
                anode_nx = '1;
                blank_nx = 1'b1;
              end else begin
                sel_nx = next_idx;
                // Wrap (including a lone digit re-selecting itself) ends a frame.
                fd_nx  = (next_idx <= digit_sel);
                if (BLANK_TICKS == 0) begin
                  state_nx = S_SHOW;
                  anode_nx = lit_anode(next_idx);
                  blank_nx = 1'b0;
                end else begin
                  state_nx = S_BLANK;
                  anode_nx = '1;
                  blank_nx = 1'b1;
                end
              end
            end else begin
              cnt_nx = cnt + CNT_W'(1);
            end
          end
        end

        default: begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
          anode_nx = '1;
          blank_nx = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Purpose: self-checking bench for display_scan_scheduler (scoreboard of lit digits).
// Latency: n/a.
// Backpressure: n/a.
module tb_display_scan_scheduler;

  localparam int DIVP = 8;       // div_clock period in system clocks
  localparam int LIT  = 4 * DIVP; // SHOW_TICKS ticks
  localparam int BLK  = 1 * DIVP; // BLANK_TICKS ticks

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       div_clock = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] digit_mask = 4'b0000;
  logic [3:0] anode;
  logic [1:0] digit_sel;
  logic       blank;
  logic       frame_done;

  display_scan_scheduler #(
    .NUM_DIGITS  (4),
    .SHOW_TICKS  (4),
    .BLANK_TICKS (1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .div_clock  (div_clock),
    .enable     (enable),
    .digit_mask (digit_mask),
    .anode      (anode),
    .digit_sel  (digit_sel),
    .blank      (blank),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  initial begin
    forever begin
      repeat (DIVP / 2) @(negedge clock);
      div_clock = ~div_clock;
    end
  end

  typedef struct {
    int sel;
    int anode;
    int fd;    // frame_done pulses expected since the previous lit start
    int len;   // expected lit length in clocks, 0 = not checked
    int blen;  // expected preceding blank length in clocks, 0 = not checked
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push(input int sel, input int an, input int fd, input int len, input int blen);
    exp_t x;
    x.sel = sel; x.anode = an; x.fd = fd; x.len = len; x.blen = blen;
    sb.push_back(x);
  endtask

  task automatic wait_sb(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_drain"}, sb.size(), 0);
    sb.delete();
  endtask

  // Monitor: pops one entry at every lit start and measures lit/blank run lengths.
  bit         mon_en = 1'b0;
  bit         prev_lit = 1'b0;
  logic [1:0] prev_sel = 2'd0;
  int         lit_len = 0;
  int         blank_len = 0;
  int         fd_cnt = 0;
  int         cur_len = 0;

  always @(negedge clock) begin
    if (mon_en) begin
      check("anode_form", anode, blank ? 4'hF : (4'hF & ~(4'h1 << digit_sel)));
      if (frame_done) fd_cnt++;
      if (!blank) begin
        if (!prev_lit || digit_sel != prev_sel) begin
          if (prev_lit && cur_len != 0) check("lit_len", lit_len, cur_len);
          if (sb.size() == 0) begin
            check("unexpected_lit", 1, 0);
            cur_len = 0;
          end else begin
            e = sb.pop_front();
            check("digit_sel", digit_sel, e.sel);
            check("anode", anode, e.anode);
            check("frame_done_cnt", fd_cnt, e.fd);
            if (!prev_lit && e.blen != 0) check("blank_len", blank_len, e.blen);
            cur_len = e.len;
          end
          fd_cnt  = 0;
          lit_len = 1;
        end else begin
          lit_len++;
        end
      end else begin
        if (prev_lit) begin
          if (cur_len != 0) check("lit_len", lit_len, cur_len);
          blank_len = 1;
        end else begin
          blank_len++;
        end
      end
      prev_lit = !blank;
      prev_sel = digit_sel;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clock);
    check("rst_anode", anode, 4'hF);
    check("rst_blank", blank, 1);
    check("rst_sel", digit_sel, 0);
    check("rst_fd", frame_done, 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Full scan 0,1,2,3,0 with a wrap pulse only on 3 -> 0.
    push(0, 4'b1110, 0, LIT, 0);
    push(1, 4'b1101, 0, LIT, BLK);
    push(2, 4'b1011, 0, LIT, BLK);
    push(3, 4'b0111, 0, LIT, BLK);
    push(0, 4'b1110, 1, LIT, BLK);
    push(1, 4'b1101, 0, 0,   BLK);
    digit_mask = 4'b1111;
    enable     = 1'b1;
    wait_sb("t2", 600);

    // Sparse mask: 1,3 alternate, wrap on 3 -> 1.
    enable = 1'b0;
    repeat (4) @(negedge clock);
    check("idle_blank", blank, 1);
    push(1, 4'b1101, 0, LIT, 0);
    push(3, 4'b0111, 0, LIT, BLK);
    push(1, 4'b1101, 1, LIT, BLK);
    push(3, 4'b0111, 0, LIT, BLK);
    push(1, 4'b1101, 1, 0,   BLK);
    digit_mask = 4'b1010;
    enable     = 1'b1;
    wait_sb("t3", 600);

    // Single digit re-selects itself and wraps on every advance.
    enable = 1'b0;
    repeat (4) @(negedge clock);
    push(2, 4'b1011, 0, LIT, 0);
    push(2, 4'b1011, 1, LIT, BLK);
    push(2, 4'b1011, 1, LIT, BLK);
    push(2, 4'b1011, 1, 0,   BLK);
    digit_mask = 4'b0100;
    enable     = 1'b1;
    wait_sb("t4", 600);

    // Drop enable while digit 2 is lit.
    enable = 1'b0;
    repeat (4) @(negedge clock);
    push(0, 4'b1110, 0, LIT, 0);
    push(1, 4'b1101, 0, LIT, BLK);
    push(2, 4'b1011, 0, 0,   BLK);
    digit_mask = 4'b1111;
    enable     = 1'b1;
    wait_sb("t5", 600);
    repeat (5) @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    check("t5_anode", anode, 4'hF);
    check("t5_blank", blank, 1);
    check("t5_fd", frame_done, 0);
    repeat (3) @(negedge clock);
    push(2, 4'b1011, 0, LIT, 0);
    push(3, 4'b0111, 0, 0,   BLK);
    digit_mask = 4'b1100;
    enable     = 1'b1;
    wait_sb("t5_restart", 600);

    // Clear mask mid-SHOW: digit 1 still gets its full time, then IDLE.
    enable = 1'b0;
    repeat (4) @(negedge clock);
    push(0, 4'b1110, 0, LIT, 0);
    push(1, 4'b1101, 0, LIT, BLK);
    digit_mask = 4'b1111;
    enable     = 1'b1;
    wait_sb("t6", 600);
    digit_mask = 4'b0000;
    repeat (150) @(negedge clock);
    check("t6_idle_blank", blank, 1);
    check("t6_idle_anode", anode, 4'hF);
    push(0, 4'b1110, 0, 0, 0);
    digit_mask = 4'b0001;
    wait_sb("t6_resume", 600);
    // Mask sampled at the next advance: 0 -> 2 is not a wrap.
    push(2, 4'b1011, 0, 0, BLK);
    digit_mask = 4'b0100;
    wait_sb("t6_move", 600);

    // Asynchronous reset mid-scan, checked before any clock edge.
    repeat (3) @(negedge clock);
    #2;
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    check("t1_anode", anode, 4'hF);
    check("t1_blank", blank, 1);
    check("t1_sel", digit_sel, 0);
    check("t1_fd", frame_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
